// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: buttons, counter-chain and shared display bus of the stopwatch controller
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lap;
    logic       btn_clr;
    logic [3:0] bcd_u;
    logic [3:0] bcd_d;
    logic [3:0] bcd_c;
    logic       cnt_tick;
    logic       cnt_clr;
    logic [3:0] disp_bcd;
    logic [2:0] disp_sel;
    logic [1:0] state;
    logic       ovf;
    modport master (
        input  btn_ss, btn_lap, btn_clr, bcd_u, bcd_d, bcd_c,
        output cnt_tick, cnt_clr, disp_bcd, disp_sel, state, ovf
    );
    modport slave (
        output btn_ss, btn_lap, btn_clr, bcd_u, bcd_d, bcd_c,
        input  cnt_tick, cnt_clr, disp_bcd, disp_sel, state, ovf
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear FSM with count prescaler, lap snapshot and multiplexed BCD display
module stopwatch_ctrl #(
    parameter int PRESC_DIV = 50000,
    parameter int SCAN_DIV  = 1000
) (
    input logic              clk,
    input logic              clrn,
    stopwatch_ctrl_if.master sw
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
    localparam int PW = PRESC_DIV > 1 ? $clog2(PRESC_DIV) : 1;
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    state_t        st;
    logic [2:0]    s1, s2, prev;
    logic [PW-1:0] presc;
    logic [SW-1:0] scan;
    logic [11:0]   snap, live, shown;
    logic [2:0]    sel_n;
    logic [3:0]    bcd_n;
    logic          e_clr, e_ss, e_lap, counting, wrap_p, wrap_s;
    // button bits are kept as {clr, ss, lap}
    assign {e_clr, e_ss, e_lap} = s2 & ~prev;
    assign live     = {sw.bcd_c, sw.bcd_d, sw.bcd_u};
    assign counting = (st == RUN) || (st == LAP);
    assign wrap_p   = presc == PW'(PRESC_DIV - 1);
    assign wrap_s   = scan == SW'(SCAN_DIV - 1);
    assign sel_n    = wrap_s ? {sw.disp_sel[1:0], sw.disp_sel[2]} : sw.disp_sel;
    assign shown    = st == LAP ? snap : live;
    assign bcd_n    = sel_n[2] ? shown[11:8] : sel_n[1] ? shown[7:4] : shown[3:0];
    assign sw.state = st;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            st          <= IDLE;
            s1          <= '0;
            s2          <= '0;
            prev        <= '0;
            presc       <= '0;
            scan        <= '0;
            snap        <= '0;
            sw.cnt_tick <= 1'b0;
            sw.cnt_clr  <= 1'b0;
            sw.disp_bcd <= '0;
            sw.disp_sel <= 3'b001;
            sw.ovf      <= 1'b0;
        end else begin
            s1          <= {sw.btn_clr, sw.btn_ss, sw.btn_lap};
            s2          <= s1;
            prev        <= s2;
            scan        <= wrap_s ? '0 : scan + 1'b1;
            sw.disp_sel <= sel_n;
            sw.disp_bcd <= bcd_n;
            sw.cnt_clr  <= 1'b0;
            sw.cnt_tick <= counting && wrap_p;
            if (counting) presc <= wrap_p ? '0 : presc + 1'b1;
            if (sw.cnt_tick && live == 12'h999) sw.ovf <= 1'b1;
            case (st)
                IDLE: begin
                    if (e_clr) begin
                        sw.cnt_clr <= 1'b1;
                        sw.ovf     <= 1'b0;
                    end else if (e_ss) st <= RUN;
                end
                RUN: begin
                    if (e_ss) st <= PAUSE;
                    else if (e_lap) begin
                        st   <= LAP;
                        snap <= live;
                    end
                end
                LAP: begin
                    if (e_ss) st <= PAUSE;
                    else if (e_lap) st <= RUN;
                end
                PAUSE: begin
                    if (e_clr) begin
                        st          <= IDLE;
                        sw.cnt_clr  <= 1'b1;
                        sw.ovf      <= 1'b0;
                        presc       <= '0;
                        sw.cnt_tick <= 1'b0;
                    end else if (e_ss) st <= RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scoreboard bench for stopwatch_ctrl driving a behavioural 0..999 BCD counter
module tb_stopwatch_ctrl;
    localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11;
    localparam logic [2:0] CL = 3'b100, SS = 3'b010, LP = 3'b001;
    typedef struct { int cyc; int val; } ev_t;
    typedef struct packed { logic [2:0] sel; logic [3:0] bcd; } dv_t;
    logic       clk = 1'b0, clrn = 1'b1, pre_req = 1'b0;
    logic [2:0] btn = '0;
    int         cnt = 0, pre_val = 0, cyc = 0, errs = 0, checks = 0;
    ev_t        q_state[$], q_ovf[$];
    dv_t        q_disp[$];
    int         q_tick[$], q_clr[$];
    logic [1:0] ps = IDLE;
    logic       po = 1'b0;
    logic [2:0] psel = 3'b001;

    stopwatch_ctrl_if sw();
    stopwatch_ctrl #(.PRESC_DIV(4), .SCAN_DIV(2)) dut (.clk(clk), .clrn(clrn), .sw(sw));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign {sw.btn_clr, sw.btn_ss, sw.btn_lap} = btn;
    always @(posedge clk or negedge clrn)
        if (!clrn) cnt <= 0;
        else if (pre_req) cnt <= pre_val;
        else if (sw.cnt_clr) cnt <= 0;
        else if (sw.cnt_tick) cnt <= cnt == 999 ? 0 : cnt + 1;
    assign sw.bcd_u = 4'(cnt % 10);
    assign sw.bcd_d = 4'(cnt / 10 % 10);
    assign sw.bcd_c = 4'(cnt / 100);

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic bad(string name, int v);
        checks++;
        errs++;
        $display("FAIL %s: cycle/value %0d", name, v);
    endtask
    task automatic chk_reset(string tag);
        chk({tag, " state"}, int'(sw.state), 0);
        chk({tag, " cnt_tick"}, int'(sw.cnt_tick), 0);
        chk({tag, " cnt_clr"}, int'(sw.cnt_clr), 0);
        chk({tag, " disp_bcd"}, int'(sw.disp_bcd), 0);
        chk({tag, " disp_sel"}, int'(sw.disp_sel), 1);
        chk({tag, " ovf"}, int'(sw.ovf), 0);
    endtask
    task automatic at(int c);
        while (cyc < c) @(negedge clk);
    endtask
    task automatic go(logic [2:0] m);
        btn = m;
        repeat (3) @(negedge clk);
        btn = '0;
        repeat (3) @(negedge clk);
    endtask
    task automatic push_state(int c, logic [1:0] s);
        ev_t e;
        e.cyc = c;
        e.val = int'(s);
        q_state.push_back(e);
    endtask
    task automatic push_ovf(int c, int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        q_ovf.push_back(e);
    endtask
    task automatic push_disp(logic [3:0] u, logic [3:0] d, logic [3:0] h);
        q_disp.push_back({3'b001, u});
        q_disp.push_back({3'b010, d});
        q_disp.push_back({3'b100, h});
    endtask
    task automatic exp_ticks(int first, int last);
        for (int x = first; x <= last; x += 4) q_tick.push_back(x);
    endtask
    task automatic preload(int v);
        pre_val = v;
        pre_req = 1'b1;
        @(negedge clk);
        pre_req = 1'b0;
    endtask

    always @(negedge clk) begin
        ev_t e;
        dv_t d;
        if (sw.state != ps) begin
            if (q_state.size() == 0) bad("unexpected state change at cycle", cyc);
            else begin
                e = q_state.pop_front();
                chk("state value", int'(sw.state), e.val);
                chk("state change cycle", cyc, e.cyc);
            end
            ps = sw.state;
        end
        if (sw.cnt_tick) begin
            if (q_tick.size() == 0) bad("unexpected cnt_tick at cycle", cyc);
            else chk("cnt_tick cycle", cyc, q_tick.pop_front());
        end
        if (sw.cnt_clr) begin
            if (q_clr.size() == 0) bad("unexpected cnt_clr at cycle", cyc);
            else chk("cnt_clr cycle", cyc, q_clr.pop_front());
        end
        if (sw.ovf != po) begin
            if (q_ovf.size() == 0) bad("unexpected ovf change at cycle", cyc);
            else begin
                e = q_ovf.pop_front();
                chk("ovf value", int'(sw.ovf), e.val);
                chk("ovf change cycle", cyc, e.cyc);
            end
            po = sw.ovf;
        end
        if (sw.disp_sel != psel) begin
            if (q_disp.size() != 0 && q_disp[0].sel == sw.disp_sel) begin
                d = q_disp.pop_front();
                chk($sformatf("disp_bcd on sel %b", d.sel), int'(sw.disp_bcd), int'(d.bcd));
            end
            psel = sw.disp_sel;
        end
    end

    initial begin
        int e, p, r, c;
        #2 clrn = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        clrn = 1'b1;
        // start from IDLE, 4-cycle tick cadence
        at(cyc + 2);
        e = cyc + 3;
        push_state(e, RUN);
        exp_ticks(e + 4, e + 74);
        go(SS);
        at(e + 12);
        chk("count after 12 cycles-1", cnt, 2);
        at(e + 13);
        chk("count after 13 cycles", cnt, 3);
        // lap at 012, snapshot shown while live keeps counting
        at(e + 48);
        push_state(e + 51, LAP);
        go(LP);
        at(e + 56);
        push_disp(4'd2, 4'd1, 4'd0);
        at(e + 64);
        push_state(e + 67, RUN);
        go(LP);
        at(e + 71);
        p = e + 74;
        push_state(p, PAUSE);
        go(SS);
        at(p + 4);
        push_disp(4'd8, 4'd1, 4'd0);
        // partial prescaler period kept across pause
        at(p + 24);
        chk("count held in pause", cnt, 18);
        r = p + 27;
        push_state(r, RUN);
        exp_ticks(r + 2, r + 12);
        go(SS);
        at(r + 3);
        go(CL);
        chk("state after clr in RUN", int'(sw.state), int'(RUN));
        at(r + 9);
        p = r + 12;
        push_state(p, PAUSE);
        go(SS);
        // 999 wrap sets sticky ovf
        at(p + 3);
        preload(999);
        chk("preloaded count", cnt, 999);
        at(p + 5);
        push_disp(4'd9, 4'd9, 4'd9);
        at(p + 12);
        r = p + 15;
        push_state(r, RUN);
        exp_ticks(r + 2, r + 12);
        push_ovf(r + 3, 1);
        go(SS);
        at(r + 3);
        chk("count after wrap", cnt, 0);
        at(r + 9);
        p = r + 12;
        push_state(p, PAUSE);
        go(SS);
        at(p + 3);
        r = p + 6;
        push_state(r, RUN);
        exp_ticks(r + 2, r + 9);
        go(SS);
        at(r + 6);
        p = r + 9;
        push_state(p, PAUSE);
        go(SS);
        // clr in PAUSE with prescaler parked at 3
        at(p + 3);
        chk("count before clr", cnt, 4);
        chk("ovf still set", int'(sw.ovf), 1);
        c = p + 6;
        push_state(c, IDLE);
        q_clr.push_back(c);
        push_ovf(c, 0);
        go(CL);
        at(c + 3);
        chk("count after cnt_clr", cnt, 0);
        e = c + 6;
        push_state(e, RUN);
        exp_ticks(e + 4, e + 6);
        go(SS);
        at(e + 3);
        p = e + 6;
        push_state(p, PAUSE);
        go(SS);
        // clr and ss together in PAUSE
        at(p + 3);
        c = p + 6;
        push_state(c, IDLE);
        q_clr.push_back(c);
        go(SS | CL);
        // async reset mid-RUN with ovf set
        at(c + 3);
        chk("count after clr+ss", cnt, 0);
        preload(999);
        e = c + 7;
        push_state(e, RUN);
        exp_ticks(e + 4, e + 6);
        push_ovf(e + 5, 1);
        go(SS);
        at(e + 6);
        chk("ovf before async reset", int'(sw.ovf), 1);
        #1 clrn = 1'b0;
        #1 chk_reset("async reset");
        push_state(e + 7, IDLE);
        push_ovf(e + 7, 0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (4) @(negedge clk);
        foreach (q_state[i]) bad("missing state change at cycle", q_state[i].cyc);
        foreach (q_ovf[i]) bad("missing ovf change at cycle", q_ovf[i].cyc);
        foreach (q_tick[i]) bad("missing cnt_tick at cycle", q_tick[i]);
        foreach (q_clr[i]) bad("missing cnt_clr at cycle", q_clr[i]);
        foreach (q_disp[i]) bad("missing display digit", int'(q_disp[i].bcd));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
